hilo_guess_judge: RTL and testbench



---
 rtl/hilo_pkg.sv | 17 +
 rtl/hilo_guess_judge_sat_counter.sv | 27 ++
 rtl/hilo_guess_judge.sv | 153 +++++++++++++++
 tb/tb_hilo_guess_judge.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Definitions shared by the high/low game blocks: judge states, guess encoding
// and the display-limited score ceiling.
package hilo_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      RESULT = 2'd2
   } judge_state_t;

   localparam logic GUESS_HI = 1'b1;
   localparam logic GUESS_LO = 1'b0;

   // Two-digit seven-segment display ceiling
   localparam int SCORE_MAX = 99;

endpackage

// File: rtl/hilo_guess_judge_sat_counter.sv
// Up-counter with synchronous clear that holds at MAX instead of wrapping.
module sat_counter
   import hilo_pkg::*;
#(
   parameter int W   = 8,
   parameter int MAX = hilo_pkg::SCORE_MAX
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] Q_MAX = W'(MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q < Q_MAX)) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/hilo_guess_judge.sv
// Judges a latched high/low guess against the next outcome pulse and keeps
// score, current streak and best streak for the display.
//
// state  | meaning
// IDLE   | waiting for a single guess pulse
// ARMED  | guess latched, waiting for one valid h/l outcome or timeout
// RESULT | win/lose held for HOLD_CYCLES, then back to IDLE
module hilo_guess_judge
   import hilo_pkg::*;
#(
   parameter int SCORE_W        = 8,
   parameter int SCORE_MAX      = hilo_pkg::SCORE_MAX,
   parameter int HOLD_CYCLES    = 50_000_000,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               guess_hi,
   input  logic               guess_lo,
   input  logic               h,
   input  logic               l,
   output logic               armed,
   output logic               win,
   output logic               lose,
   output logic               timeout,
   output logic               proto_err,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] streak,
   output logic [SCORE_W-1:0] best
);

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_ARMED  = ARMED;
   localparam logic [1:0] ST_RESULT = RESULT;

   localparam int HW = (HOLD_CYCLES > 1)    ? $clog2(HOLD_CYCLES)    : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0]      TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [SCORE_W-1:0] S_MAX     = SCORE_W'(SCORE_MAX);

   logic [1:0]         state;
   logic               guess_q;
   logic [HW-1:0]      hold_cnt;
   logic [TW-1:0]      tmo_cnt;

   logic               outcome_ok;
   logic               correct;
   logic               judge;
   logic               tmo_hit;
   logic               pt_inc;
   logic               streak_clr;
   logic [SCORE_W-1:0] streak_next;

   always_comb begin
      outcome_ok  = h ^ l;
      correct     = ((h ? GUESS_HI : GUESS_LO) == guess_q);
      judge       = (state == ST_ARMED) && outcome_ok;
      tmo_hit     = (state == ST_ARMED) && !outcome_ok && (tmo_cnt == TMO_LAST);
      pt_inc      = judge && correct;
      streak_clr  = (judge && !correct) || tmo_hit;
      streak_next = streak;
      if (streak_clr) begin
         streak_next = '0;
      end else if (pt_inc && (streak < S_MAX)) begin
         streak_next = streak + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         guess_q   <= GUESS_LO;
         hold_cnt  <= '0;
         tmo_cnt   <= '0;
         armed     <= 1'b0;
         win       <= 1'b0;
         lose      <= 1'b0;
         timeout   <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         timeout   <= 1'b0;
         proto_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (guess_hi ^ guess_lo) begin
                  guess_q <= guess_hi ? GUESS_HI : GUESS_LO;
                  tmo_cnt <= '0;
                  armed   <= 1'b1;
                  state   <= ST_ARMED;
               end
            end
            ST_ARMED: begin
               proto_err <= h & l;
               // A valid outcome wins over an expiring count in the same cycle
               if (outcome_ok) begin
                  win      <= correct;
                  lose     <= !correct;
                  hold_cnt <= '0;
                  armed    <= 1'b0;
                  state    <= ST_RESULT;
               end else if (tmo_cnt == TMO_LAST) begin
                  timeout <= 1'b1;
                  armed   <= 1'b0;
                  state   <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_RESULT: begin
               if (hold_cnt == HOLD_LAST) begin
                  win   <= 1'b0;
                  lose  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               armed <= 1'b0;
               win   <= 1'b0;
               lose  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         best <= '0;
      end else if (streak_next > best) begin
         best <= streak_next;
      end
   end

   sat_counter #(.W(SCORE_W), .MAX(SCORE_MAX)) u_score (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pt_inc),
      .clr   (1'b0),
      .q     (score)
   );

   sat_counter #(.W(SCORE_W), .MAX(SCORE_MAX)) u_streak (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pt_inc),
      .clr   (streak_clr),
      .q     (streak)
   );

endmodule

// File: tb/tb_hilo_guess_judge.sv
// Directed bench for hilo_guess_judge with a short hold, short timeout and a
// ceiling of 3 so saturation is reachable.
module tb_hilo_guess_judge;

   localparam int SW   = 8;
   localparam int SMAX = 3;
   localparam int HOLD = 4;
   localparam int TMO  = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          guess_hi = 1'b0;
   logic          guess_lo = 1'b0;
   logic          h = 1'b0;
   logic          l = 1'b0;
   logic          armed, win, lose, timeout, proto_err;
   logic [SW-1:0] score, streak, best;

   int n_chk = 0;
   int n_err = 0;

   hilo_guess_judge #(
      .SCORE_W(SW), .SCORE_MAX(SMAX), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .guess_hi(guess_hi), .guess_lo(guess_lo),
      .h(h), .l(l), .armed(armed), .win(win), .lose(lose), .timeout(timeout),
      .proto_err(proto_err), .score(score), .streak(streak), .best(best)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_guess(input logic hi);
      guess_hi = hi;
      guess_lo = !hi;
      tick();
      guess_hi = 1'b0;
      guess_lo = 1'b0;
   endtask

   task automatic do_out(input logic hv);
      h = hv;
      l = !hv;
      tick();
      h = 1'b0;
      l = 1'b0;
   endtask

   task automatic flags(input string tag, input int exp);
      check(tag, int'({armed, win, lose, timeout, proto_err}), exp);
   endtask

   task automatic counts(input string tag, input int s, input int k, input int b);
      check({tag, "_score"}, int'(score), s);
      check({tag, "_streak"}, int'(streak), k);
      check({tag, "_best"}, int'(best), b);
   endtask

   task automatic round(input logic g, input logic o);
      do_guess(g);
      do_out(o);
      repeat (HOLD) tick();
   endtask

   initial begin
      // flags vector is {armed, win, lose, timeout, proto_err}
      tick();
      tick();
      flags("reset_flags", 0);
      counts("reset", 0, 0, 0);
      rst_n = 1'b1;

      guess_hi = 1'b1;
      guess_lo = 1'b1;
      tick();
      guess_hi = 1'b0;
      guess_lo = 1'b0;
      flags("both_guess_ignored", 0);

      do_guess(1'b1);
      flags("armed_after_guess", 5'b10000);
      guess_lo = 1'b1;
      tick();
      guess_lo = 1'b0;
      flags("armed_hold", 5'b10000);
      do_out(1'b1);
      flags("r1_win", 5'b01000);
      counts("r1", 1, 1, 1);
      for (int i = 0; i < HOLD - 1; i++) begin
         tick();
         check("r1_win_held", int'(win), 1);
      end
      tick();
      flags("r1_back_idle", 0);

      round(1'b0, 1'b0);
      round(1'b1, 1'b1);
      counts("three_wins", 3, 3, 3);
      do_guess(1'b0);
      do_out(1'b1);
      flags("r4_lose", 5'b00100);
      counts("r4", 3, 0, 3);
      repeat (HOLD) tick();

      do_guess(1'b1);
      h = 1'b1;
      l = 1'b1;
      tick();
      h = 1'b0;
      l = 1'b0;
      flags("proto_err_pulse", 5'b10001);
      tick();
      flags("proto_err_clear", 5'b10000);
      do_out(1'b0);
      flags("after_proto_lose", 5'b00100);
      counts("after_proto", 3, 0, 3);
      repeat (HOLD) tick();

      round(1'b1, 1'b1);
      counts("pre_timeout", 3, 1, 3);
      do_guess(1'b0);
      repeat (TMO - 1) tick();
      flags("tmo_still_armed", 5'b10000);
      tick();
      flags("tmo_pulse", 5'b00010);
      counts("tmo", 3, 0, 3);
      tick();
      flags("tmo_pulse_end", 0);

      do_guess(1'b0);
      repeat (TMO - 1) tick();
      do_out(1'b0);
      flags("tmo_edge_win", 5'b01000);
      counts("tmo_edge", 3, 1, 3);
      repeat (HOLD) tick();

      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         round(1'b1, 1'b1);
         check("sat_score", int'(score), (i < SMAX) ? i : SMAX);
         check("sat_streak", int'(streak), (i < SMAX) ? i : SMAX);
      end

      do_guess(1'b1);
      do_out(1'b1);
      flags("pre_rst_win", 5'b01000);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      flags("rst_result_flags", 0);
      counts("rst_result", 0, 0, 0);
      do_out(1'b1);
      flags("h_after_rst", 0);
      counts("h_after_rst", 0, 0, 0);

      do_guess(1'b0);
      flags("armed_pre_rst", 5'b10000);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      flags("rst_armed_flags", 0);
      do_out(1'b0);
      flags("l_after_rst", 0);
      counts("l_after_rst", 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
